// File: rtl/lsu_dmem_master.sv
// lsu_dmem_master: one-outstanding scalar load/store initiator for the dmem port; define LSU_MISALIGN_TRAP_EN to trap misaligned accesses
module lsu_dmem_master #(
  parameter int TAG_WIDTH = 5,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [TAG_WIDTH-1:0]  req_tag,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic [TAG_WIDTH-1:0]  resp_tag,
  output logic                  resp_err,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  output logic [3:0]            dmem_be,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  input  logic                  dmem_valid
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic we_q, we_d, uns_q, uns_d;
  logic [1:0] size_q, size_d, off_q, off_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;
  logic req_ready_q, req_ready_d, resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d, dmem_wdata_q, dmem_wdata_d;
  logic [TAG_WIDTH-1:0] resp_tag_q, resp_tag_d;
  logic dmem_req_q, dmem_req_d, dmem_we_q, dmem_we_d;
  logic [ADDR_WIDTH-1:0] dmem_addr_q, dmem_addr_d;
  logic [3:0] dmem_be_q, dmem_be_d;
  logic word_in, half_in, trap_in;
  logic [1:0] off_in;
  logic [3:0] be_in;
  logic [DATA_WIDTH-1:0] wd_in, sh, ld;
  assign word_in = req_size[1];
  assign half_in = req_size == 2'b01;
  assign off_in = word_in ? 2'b00 : half_in ? {req_addr[1], 1'b0} : req_addr[1:0];
  assign be_in = word_in ? 4'hf : (half_in ? 4'h3 : 4'h1) << off_in;
  assign wd_in = word_in ? req_wdata : half_in ? {2{req_wdata[15:0]}} : {4{req_wdata[7:0]}};
`ifdef LSU_MISALIGN_TRAP_EN
  assign trap_in = (half_in & req_addr[0]) | (word_in & |req_addr[1:0]);
`else
  assign trap_in = 1'b0;
`endif
  assign sh = dmem_rdata >> {off_q, 3'b000};
  assign ld = size_q[1] ? sh : size_q[0] ? {{16{~uns_q & sh[15]}}, sh[15:0]} : {{24{~uns_q & sh[7]}}, sh[7:0]};
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    we_d = we_q;
    size_d = size_q;
    uns_d = uns_q;
    off_d = off_q;
    tag_d = tag_q;
    resp_valid_d = resp_valid_q;
    resp_err_d = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    resp_tag_d = resp_tag_q;
    dmem_req_d = 1'b0;
    dmem_we_d = 1'b0;
    dmem_addr_d = '0;
    dmem_wdata_d = '0;
    dmem_be_d = 4'h0;
    case (state_q)
      IDLE: if (req_valid) begin
        we_d = req_we;
        size_d = req_size;
        uns_d = req_unsigned;
        off_d = off_in;
        tag_d = req_tag;
        state_d = trap_in ? RESP : ISSUE;
        resp_valid_d = trap_in;
        resp_err_d = trap_in;
        resp_rdata_d = '0;
        resp_tag_d = trap_in ? req_tag : '0;
        dmem_req_d = ~trap_in;
        dmem_we_d = ~trap_in & req_we;
        dmem_addr_d = trap_in ? '0 : {req_addr[ADDR_WIDTH-1:2], 2'b00};
        dmem_wdata_d = trap_in ? '0 : wd_in;
        dmem_be_d = trap_in ? 4'h0 : be_in;
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d = '0;
      end
      WAIT: if (dmem_valid || cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
        state_d = RESP;
        resp_valid_d = 1'b1;
        resp_err_d = ~dmem_valid;
        resp_rdata_d = (dmem_valid && !we_q) ? ld : '0;
        resp_tag_d = tag_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      RESP: if (resp_ready) begin
        state_d = IDLE;
        resp_valid_d = 1'b0;
        resp_err_d = 1'b0;
        resp_rdata_d = '0;
        resp_tag_d = '0;
      end
      default: state_d = IDLE;
    endcase
    req_ready_d = state_d == IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      we_q <= 1'b0;
      size_q <= 2'b00;
      uns_q <= 1'b0;
      off_q <= 2'b00;
      tag_q <= '0;
      req_ready_q <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_tag_q <= '0;
      dmem_req_q <= 1'b0;
      dmem_we_q <= 1'b0;
      dmem_addr_q <= '0;
      dmem_wdata_q <= '0;
      dmem_be_q <= 4'h0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      we_q <= we_d;
      size_q <= size_d;
      uns_q <= uns_d;
      off_q <= off_d;
      tag_q <= tag_d;
      req_ready_q <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      resp_tag_q <= resp_tag_d;
      dmem_req_q <= dmem_req_d;
      dmem_we_q <= dmem_we_d;
      dmem_addr_q <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      dmem_be_q <= dmem_be_d;
    end
  end
  assign req_ready = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_tag = resp_tag_q;
  assign dmem_req = dmem_req_q;
  assign dmem_we = dmem_we_q;
  assign dmem_addr = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign dmem_be = dmem_be_q;
endmodule

// File: tb/tb_lsu_dmem_master.sv
// tb_lsu_dmem_master: randomized self-checking bench with a byte-array reference memory and a 1-cycle dmem responder
module tb_lsu_dmem_master;
  localparam int TO = 16;
  logic clk = 1'b0;
  logic rst_n;
  logic req_valid, req_ready, req_we, req_unsigned, resp_valid, resp_ready, resp_err;
  logic [1:0] req_size;
  logic [31:0] req_addr, req_wdata, resp_rdata, dmem_addr, dmem_wdata, dmem_rdata;
  logic [4:0] req_tag, resp_tag;
  logic dmem_req, dmem_we, dmem_valid;
  logic [3:0] dmem_be;
  logic [7:0] mm [0:1023];
  logic [7:0] ref_m [0:1023];
  logic mem_on;
  int req_count = 0;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0] cap_be;
  logic cap_we;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  lsu_dmem_master #(.TAG_WIDTH(5), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_tag(req_tag), .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_tag(resp_tag), .resp_err(resp_err), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
    .dmem_valid(dmem_valid)
  );
  initial begin
    logic [31:0] rd;
    int a;
    for (int i = 0; i < 1024; i++) mm[i] = 8'h00;
    dmem_valid = 1'b0;
    dmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (dmem_req === 1'b1) begin
        req_count++;
        cap_addr = dmem_addr;
        cap_be = dmem_be;
        cap_wdata = dmem_wdata;
        cap_we = dmem_we;
        if (mem_on) begin
          a = int'(dmem_addr[9:0]);
          if (dmem_we) for (int i = 0; i < 4; i++) if (dmem_be[i]) mm[a + i] = dmem_wdata[8*i +: 8];
          rd = {mm[a + 3], mm[a + 2], mm[a + 1], mm[a]};
          @(posedge clk);
          #1;
          dmem_valid = 1'b1;
          dmem_rdata = rd;
          @(posedge clk);
          #1;
          dmem_valid = 1'b0;
          dmem_rdata = $urandom;
        end
      end
    end
  end
  task automatic model(input logic we, input logic [1:0] size, input logic uns, input logic [31:0] addr,
                       input logic [31:0] wd, output logic [31:0] e_addr, output logic [3:0] e_be,
                       output logic [31:0] e_wd, output logic [31:0] e_rd, output logic e_err, output logic e_issue);
    int n, ea, lane;
    longint v;
    n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    e_err = 1'b0;
    e_issue = 1'b1;
    e_rd = '0;
`ifdef LSU_MISALIGN_TRAP_EN
    if (int'(addr % n) != 0) begin
      e_err = 1'b1;
      e_issue = 1'b0;
    end
`endif
    ea = int'(addr) - int'(addr % n);
    e_addr = 32'(ea - ea % 4);
    lane = ea % 4;
    e_be = 4'(((1 << n) - 1) << lane);
    for (int i = 0; i < 4; i++) e_wd[8*i +: 8] = wd[8*(i % n) +: 8];
    if (e_issue && we) for (int i = 0; i < n; i++) ref_m[ea + i] = wd[8*i +: 8];
    if (e_issue && !we) begin
      v = 0;
      for (int i = 0; i < n; i++) v += longint'(ref_m[ea + i]) << (8 * i);
      if (!uns && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
      e_rd = v[31:0];
    end
  endtask
  task automatic access(input logic we, input logic [1:0] size, input logic uns, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [4:0] tag, input string nm);
    logic [31:0] e_addr, e_wd, e_rd;
    logic [3:0] e_be;
    logic e_err, e_issue;
    int base, lat, e_lat;
    model(we, size, uns, addr, wd, e_addr, e_be, e_wd, e_rd, e_err, e_issue);
    e_lat = e_issue ? 2 : 0;
    base = req_count;
    @(negedge clk);
    req_valid = 1'b1;
    req_we = we;
    req_size = size;
    req_unsigned = uns;
    req_addr = addr;
    req_wdata = wd;
    req_tag = tag;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 0;
    while (resp_valid !== 1'b1 && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (lat !== e_lat) begin errors++; $display("FAIL %s latency: got %0d exp %0d", nm, lat, e_lat); end
    checks++;
    if (req_count !== base + (e_issue ? 1 : 0)) begin errors++; $display("FAIL %s dmem_req count: got %0d exp %0d", nm, req_count - base, e_issue ? 1 : 0); end
    if (e_issue) begin
      checks++;
      if (cap_addr !== e_addr) begin errors++; $display("FAIL %s dmem_addr: got %h exp %h", nm, cap_addr, e_addr); end
      checks++;
      if (cap_be !== e_be) begin errors++; $display("FAIL %s dmem_be: got %b exp %b", nm, cap_be, e_be); end
      checks++;
      if (cap_we !== we) begin errors++; $display("FAIL %s dmem_we: got %b exp %b", nm, cap_we, we); end
      if (we) begin
        checks++;
        if (cap_wdata !== e_wd) begin errors++; $display("FAIL %s dmem_wdata: got %h exp %h", nm, cap_wdata, e_wd); end
      end
    end
    checks++;
    if (resp_rdata !== e_rd) begin errors++; $display("FAIL %s resp_rdata: got %h exp %h", nm, resp_rdata, e_rd); end
    checks++;
    if (resp_err !== e_err) begin errors++; $display("FAIL %s resp_err: got %b exp %b", nm, resp_err, e_err); end
    checks++;
    if (resp_tag !== tag) begin errors++; $display("FAIL %s resp_tag: got %h exp %h", nm, resp_tag, tag); end
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    checks++;
    if ({req_ready, resp_valid} !== 2'b10) begin errors++; $display("FAIL %s release: got ready/valid %b exp 10", nm, {req_ready, resp_valid}); end
  endtask
  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({resp_valid, resp_err, resp_rdata, resp_tag, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be} !== '0) begin
      errors++; $display("FAIL reset outputs: got nonzero dmem_be=%b resp_valid=%b exp all 0", dmem_be, resp_valid);
    end
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset req_ready: got %b exp 1", req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL post-reset req_ready: got %b exp 1", req_ready); end
  endtask
  task automatic test_word;
    access(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 5'd1, "sw");
    access(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 5'd2, "lw");
  endtask
  task automatic test_byte;
    access(1'b1, 2'b00, 1'b0, 32'h103, 32'h00000080, 5'd3, "sb");
    access(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 5'd4, "lb");
    access(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 5'd5, "lbu");
  endtask
  task automatic test_half;
    access(1'b1, 2'b01, 1'b0, 32'h202, 32'h00008001, 5'd6, "sh");
    access(1'b0, 2'b01, 1'b0, 32'h202, 32'h0, 5'd7, "lh");
    access(1'b0, 2'b01, 1'b1, 32'h202, 32'h0, 5'd8, "lhu");
  endtask
  task automatic test_misalign;
    access(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 5'd9, "lw_mis");
    access(1'b0, 2'b01, 1'b1, 32'h103, 32'h0, 5'd10, "lhu_mis");
  endtask
  task automatic test_random;
    for (int k = 0; k < 40; k++)
      access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             32'h300 + 32'($urandom_range(0, 31)), $urandom, 5'($urandom), "rand");
  endtask
  task automatic test_stall;
    logic [31:0] e_addr, e_wd, e_rd;
    logic [3:0] e_be;
    logic e_err, e_issue;
    int base, lat;
    access(1'b1, 2'b10, 1'b0, 32'h3C0, 32'h5A5AC3C3, 5'd11, "stall_sw");
    model(1'b0, 2'b00, 1'b0, 32'h3C1, 32'h0, e_addr, e_be, e_wd, e_rd, e_err, e_issue);
    @(negedge clk);
    req_valid = 1'b1;
    req_we = 1'b0;
    req_size = 2'b00;
    req_unsigned = 1'b0;
    req_addr = 32'h3C1;
    req_tag = 5'h15;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 0;
    while (resp_valid !== 1'b1 && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    @(negedge clk);
    req_valid = 1'b1;
    req_we = 1'b1;
    req_addr = 32'h10;
    base = req_count;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({resp_valid, resp_err, resp_rdata, resp_tag, req_ready} !== {1'b1, 1'b0, e_rd, 5'h15, 1'b0}) begin
        errors++; $display("FAIL stall hold: got v=%b rd=%h tag=%h rdy=%b exp v=1 rd=%h tag=15 rdy=0", resp_valid, resp_rdata, resp_tag, req_ready, e_rd);
      end
    end
    checks++;
    if (req_count !== base) begin errors++; $display("FAIL stall extra dmem_req: got %0d exp 0", req_count - base); end
    @(negedge clk);
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask
  task automatic test_timeout;
    int lat;
    mem_on = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_we = 1'b0;
    req_size = 2'b10;
    req_addr = 32'h100;
    req_tag = 5'd7;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 0;
    while (resp_valid !== 1'b1 && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (lat !== TO + 1) begin errors++; $display("FAIL timeout latency: got %0d exp %0d", lat, TO + 1); end
    checks++;
    if ({resp_err, resp_rdata, resp_tag} !== {1'b1, 32'h0, 5'd7}) begin
      errors++; $display("FAIL timeout resp: got err=%b rd=%h tag=%h exp err=1 rd=0 tag=07", resp_err, resp_rdata, resp_tag);
    end
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    mem_on = 1'b1;
  endtask
  task automatic test_reset_mid;
    mem_on = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_we = 1'b1;
    req_size = 2'b10;
    req_addr = 32'h104;
    req_wdata = 32'hFFFFFFFF;
    req_tag = 5'd12;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({resp_valid, resp_err, resp_rdata, resp_tag, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be} !== '0) begin
      errors++; $display("FAIL mid reset outputs: got resp_valid=%b dmem_req=%b exp all 0", resp_valid, dmem_req);
    end
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL mid reset req_ready: got %b exp 1", req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    mem_on = 1'b1;
    access(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 5'd13, "post_reset_lw");
  endtask
  initial begin
    for (int i = 0; i < 1024; i++) ref_m[i] = 8'h00;
    rst_n = 1'b0;
    mem_on = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_size = 2'b00;
    req_unsigned = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    req_tag = '0;
    resp_ready = 1'b0;
    test_reset;
    test_word;
    test_byte;
    test_half;
    test_misalign;
    test_random;
    test_stall;
    test_timeout;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
